mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, address width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 16, data word width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 128, number of implemented words (valid addresses 0..DEPTH-1).
REQ-004 The block SHALL have parameter WAIT_CYCLES, default 2, wait-state count inserted before each access (0 legal).
REQ-005 Port clk  input  1  single clock; all state changes on rising edge.
REQ-006 Port reset  input  1  synchronous, active-high reset.
REQ-007 Port mem_en  input  1  request strobe from the control unit.
REQ-008 Port read_write  input  1  1 = read, 0 = write.
REQ-009 Port addr  input  ADDR_W  word address of the request.
REQ-010 Port wdata  input  DATA_W  write data.
REQ-011 Port rdata  output  DATA_W  read data, registered, held until the next completed read or reset.
REQ-012 Port ready  output  1  one-cycle completion pulse.
REQ-013 Port busy  output  1  high while a request is in flight (WAIT or DONE).
REQ-014 Port err  output  1  out-of-range flag, valid only while ready=1.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and DONE, and SHALL leave reset in IDLE.
REQ-016 In IDLE, mem_en=1 at a rising edge SHALL accept the request, latch addr, wdata and read_write, load wait counter = WAIT_CYCLES, and move to WAIT.
REQ-017 In WAIT with counter != 0, each edge SHALL decrement the counter.
REQ-018 In WAIT with counter == 0, the edge SHALL perform the access, set ready=1, and move to DONE.
REQ-019 On a read access, rdata SHALL load mem[latched addr] at that edge.
REQ-020 On a write access, mem[latched addr] SHALL load latched wdata at that edge, and rdata SHALL be unchanged.
REQ-021 In DONE, the next edge SHALL clear ready and err and return to IDLE.
REQ-022 mem_en in WAIT or DONE SHALL be ignored, with no queuing.
REQ-023 Latency SHALL be fixed: ready is high in the cycle following edge E0+WAIT_CYCLES+1, where E0 is the accepting edge.
REQ-024 The earliest next acceptance SHALL be at edge E0+WAIT_CYCLES+3.
REQ-025 Changes on addr, wdata, read_write or mem_en after acceptance SHALL NOT affect the in-flight transaction.
REQ-026 A latched read_write of any value other than 1'b0 (including X/Z) SHALL be treated as a read, so no write ever occurs on an unknown value.
REQ-027 If latched addr >= DEPTH, the access SHALL set err=1 with ready, perform no memory write, and load rdata = 0 on a read.
REQ-028 busy SHALL be high exactly while state is WAIT or DONE.
REQ-029 busy SHALL be 0 in IDLE, including the cycle in which mem_en is first high.
REQ-030 Memory contents SHALL initialise to all zeros at time 0 and SHALL NOT be cleared by reset.

Reset
REQ-031 reset=1 at an edge SHALL force state to IDLE, counter to 0, and rdata, ready, busy and err to 0.
REQ-032 Reset SHALL take priority over every other action at the same edge.
REQ-033 Reset asserted mid-transaction, including the access edge, SHALL abort the transaction with no memory write and no ready pulse.
REQ-034 mem_en=1 coincident with reset SHALL NOT be accepted.

Verification
REQ-035 Write then read, WAIT_CYCLES=2: write addr 8'h05 data 16'hBEEF at E0 -> ready after E3 with err=0. Then read addr 8'h05 at E5 -> ready after E8 with rdata=16'hBEEF.
REQ-036 Zero wait: WAIT_CYCLES=0, read addr 0 at E0 -> ready after E1, busy high after E0 and after E1, low after E2.
REQ-037 Out of range: write addr 8'h80 data 16'h1234 -> err=1 with ready. A following read of 8'h00 returns its prior value. A read of 8'h80 gives err=1, rdata=16'h0000.
REQ-038 Input churn: after accepting a write to 8'h10, toggle addr, wdata, read_write and mem_en every cycle -> only mem[8'h10] is changed, with exactly one ready pulse.
REQ-039 Reset mid-op: write 16'hAAAA to 8'h20, reset asserted on the access edge -> no ready. A subsequent read of 8'h20 returns the pre-reset contents, and all outputs were 0 after the reset edge.
REQ-040 Unknown direction: read_write=X at the accepting edge to 8'h30 holding 16'h5555 -> treated as a read, rdata=16'h5555, and memory is unchanged.

Source files
------------

// File: rtl/mem_responder.sv
// Fixed-latency word memory that answers one control-unit request at a time,
// inserting WAIT_CYCLES wait states before each access and flagging out-of-range addresses.
module mem_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned DEPTH       = 128,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_en,
    input  logic              read_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               rw_q;
    logic               out_of_range_c;

    // Contents start at zero and survive reset.
    logic [DATA_W-1:0]  mem [DEPTH] = '{default: '0};

    assign out_of_range_c = (32'(addr_q) >= DEPTH);

    // Request FSM; reset outranks everything, so an access edge under reset never touches memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            rdata <= '0;
            ready <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_en) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        rw_q    <= read_write;
                        cnt     <= CNT_W'(WAIT_CYCLES);
                        busy    <= 1'b1;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        ready <= 1'b1;
                        err   <= out_of_range_c;
                        state <= DONE;
                        // Only an explicit 0 writes; an unknown direction falls to the read path.
                        if (rw_q == 1'b0) begin
                            if (!out_of_range_c) begin
                                mem[IDX_W'(addr_q)] <= wdata_q;
                            end
                        end else begin
                            rdata <= out_of_range_c ? '0 : mem[IDX_W'(addr_q)];
                        end
                    end
                end
                DONE: begin
                    ready <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ready <= 1'b0;
                    err   <= 1'b0;
                end
            endcase
        end
    end

endmodule
